avr_io_arbiter: RTL and testbench

AVR_IO_ARBITER -- requirements
Module: avr_io_arbiter

---
 rtl/avr_io_arbiter_if.sv | 12 +
 rtl/avr_io_arbiter.sv | 128 ++++++++++++
 tb/tb_avr_io_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/avr_io_arbiter_if.sv
// avr_io_arbiter_if: one requester's request/response port to the I/O arbiter
interface avr_io_arbiter_if;
   logic       req;
   logic       we;
   logic [5:0] addr;
   logic [7:0] wdata;
   logic       ack;
   logic [7:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/avr_io_arbiter.sv
// avr_io_arbiter: two-requester AVR I/O bus arbiter; define AVR_IO_ARB_RR_EN for round-robin, else fixed priority with starve counter
module avr_io_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   avr_io_arbiter_if.slave  m0,
   avr_io_arbiter_if.slave  m1,
   output logic [5:0]       io_addr,
   output logic [7:0]       io_wdata,
   output logic             io_oe,
   output logic             io_write,
   output logic             io_read,
   input  logic [7:0]       io_rdata
);
   typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;

   state_t     state;
   logic       win;
   logic       pick1;
   logic       pick_we;
   logic [5:0] pick_addr;
   logic [7:0] pick_wdata;
   logic [7:0] rdata0;
   logic [7:0] rdata1;

`ifdef AVR_IO_ARB_RR_EN
   logic prefer1;

   assign pick1 = m1.req && (!m0.req || prefer1);

   // after any grant the other port becomes preferred on the next conflict
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prefer1 <= 1'b0;
      else if (state == IDLE && (m0.req || m1.req))
         prefer1 <= !pick1;
   end
`else
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve;

   assign pick1 = m1.req && (!m0.req || starve == LIM);

   // counts m0 grants that m1 had to sit through; any m1 grant or idle m1 clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve <= '0;
      else if (!m1.req)
         starve <= '0;
      else if (state == IDLE)
         starve <= pick1 ? '0 : (starve == LIM ? starve : starve + 1'b1);
   end
`endif

   assign pick_we    = pick1 ? m1.we    : m0.we;
   assign pick_addr  = pick1 ? m1.addr  : m0.addr;
   assign pick_wdata = pick1 ? m1.wdata : m0.wdata;

   // read data is forwarded straight from the bus in the ack cycle, then held in a register
   assign m0.rdata = (state == RD_DATA && !win) ? io_rdata : rdata0;
   assign m1.rdata = (state == RD_DATA &&  win) ? io_rdata : rdata1;

   // transaction FSM; bus strobes and acks are registered alongside the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         win      <= 1'b0;
         io_addr  <= '0;
         io_wdata <= '0;
         io_oe    <= 1'b0;
         io_write <= 1'b0;
         io_read  <= 1'b0;
         m0.ack   <= 1'b0;
         m1.ack   <= 1'b0;
      end else begin
         io_addr  <= '0;
         io_wdata <= '0;
         io_oe    <= 1'b0;
         io_write <= 1'b0;
         io_read  <= 1'b0;
         m0.ack   <= 1'b0;
         m1.ack   <= 1'b0;
         case (state)
            IDLE:
               if (m0.req || m1.req) begin
                  win     <= pick1;
                  io_addr <= pick_addr;
                  if (pick_we) begin
                     state    <= WR;
                     io_write <= 1'b1;
                     io_oe    <= 1'b1;
                     io_wdata <= pick_wdata;
                     m0.ack   <= !pick1;
                     m1.ack   <= pick1;
                  end else begin
                     state   <= RD_ADDR;
                     io_read <= 1'b1;
                  end
               end
            RD_ADDR: begin
               state   <= RD_DATA;
               io_read <= 1'b1;
               io_addr <= io_addr;
               m0.ack  <= !win;
               m1.ack  <= win;
            end
            default:
               state <= IDLE;
         endcase
      end
   end

   // capture the peripheral's read data for the winner at the end of the ack cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if (state == RD_DATA) begin
         if (win)
            rdata1 <= io_rdata;
         else
            rdata0 <= io_rdata;
      end
   end
endmodule

// File: tb/tb_avr_io_arbiter.sv
// tb_avr_io_arbiter: directed and random checks of the I/O arbiter against a memory-level reference
module tb_avr_io_arbiter;
   localparam int LIM = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] io_addr;
   logic [7:0] io_wdata;
   logic [7:0] io_rdata;
   logic       io_oe;
   logic       io_write;
   logic       io_read;

   avr_io_arbiter_if m0();
   avr_io_arbiter_if m1();

   avr_io_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_oe(io_oe),
      .io_write(io_write), .io_read(io_read), .io_rdata(io_rdata)
   );

   always #5 clk = ~clk;

   // peripheral: register file with a registered read port loaded while io_read is high
   logic [7:0] mem [64];
   logic [7:0] rd_reg;
   always @(posedge clk) begin
      if (io_write && io_oe) mem[io_addr] <= io_wdata;
      if (io_read) rd_reg <= mem[io_addr];
   end
   assign io_rdata = rd_reg;

   int         compared = 0;
   int         mismatched = 0;
   logic [7:0] ref_mem [64];
   logic [5:0] written [$];
   int         grants [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m0.req = 1'b0;
      m1.req = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int p, input logic we, input logic [5:0] a, input logic [7:0] d);
      if (p == 0) begin
         m0.we = we; m0.addr = a; m0.wdata = d; m0.req = 1'b1;
      end else begin
         m1.we = we; m1.addr = a; m1.wdata = d; m1.req = 1'b1;
      end
   endtask

   task automatic drop(input int p);
      if (p == 0) m0.req = 1'b0;
      else m1.req = 1'b0;
   endtask

   task automatic note_write(input logic [5:0] a, input logic [7:0] d);
      ref_mem[a] = d;
      written.push_back(a);
   endtask

   // one isolated transaction: edges from request to ack are 1 for a write, 2 for a read
   task automatic txn(input int p, input logic we, input logic [5:0] a, input logic [7:0] d);
      int   n;
      logic ack;
      logic [7:0] rd;
      set_req(p, we, a, d);
      n = 0;
      do begin
         tick();
         n++;
         ack = (p == 1) ? m1.ack : m0.ack;
      end while (!ack && n < 10);
      chk("latency", n, we ? 1 : 2);
      chk("other_ack", (p == 1) ? m0.ack : m1.ack, 0);
      chk("io_addr", io_addr, a);
      if (we) begin
         chk("io_write", {io_write, io_oe, io_read}, 3'b110);
         chk("io_wdata", io_wdata, d);
         note_write(a, d);
      end else begin
         rd = (p == 1) ? m1.rdata : m0.rdata;
         chk("io_read", {io_write, io_oe, io_read}, 3'b001);
         chk("rdata", rd, ref_mem[a]);
      end
      drop(p);
      tick();
      chk("idle_bus", {io_write, io_read, io_oe, io_addr, io_wdata, m0.ack, m1.ack}, 0);
      if (!we) chk("rdata_hold", (p == 1) ? m1.rdata : m0.rdata, ref_mem[a]);
   endtask

   initial begin
      int n;
      int p;
      logic we;
      logic [5:0] a;
      logic [7:0] d;
      m0.req = 1'b0; m0.we = 1'b0; m0.addr = '0; m0.wdata = '0;
      m1.req = 1'b0; m1.we = 1'b0; m1.addr = '0; m1.wdata = '0;

      // reset state
      #2;
      chk("reset_bus", {io_write, io_read, io_oe, io_addr, io_wdata}, 0);
      chk("reset_ack", {m0.ack, m1.ack}, 0);
      chk("reset_rdata", {m0.rdata, m1.rdata}, 0);
      do_reset();

      // GPIO DDR write from m0
      txn(0, 1'b1, 6'h17, 8'hFF);
      chk("gpio_ddr", mem[6'h17], 8'hFF);

      // PORT write then m1 read with cycle-level bus checks
      txn(0, 1'b1, 6'h18, 8'hA5);
      set_req(1, 1'b0, 6'h18, 8'h00);
      tick();
      chk("rd_addr_phase", {io_read, io_addr, m1.ack}, {1'b1, 6'h18, 1'b0});
      tick();
      chk("rd_data_phase", {io_read, io_addr, m1.ack, m0.ack}, {1'b1, 6'h18, 1'b1, 1'b0});
      chk("port_rdata", m1.rdata, 8'hA5);
      drop(1);
      tick();
      chk("rd_done", {io_read, m1.ack}, 0);
      chk("port_rdata_hold", m1.rdata, 8'hA5);

      // both requesting continuously: grant order follows the policy
      do_reset();
      set_req(0, 1'b1, 6'h20, 8'h11);
      set_req(1, 1'b1, 6'h21, 8'h22);
      n = 0;
      while (grants.size() < 10 && n < 60) begin
         tick();
         n++;
         chk("one_ack", m0.ack & m1.ack, 0);
         if (m0.ack) grants.push_back(0);
         if (m1.ack) grants.push_back(1);
      end
      drop(0);
      drop(1);
      chk("grant_count", grants.size(), 10);
      for (int k = 0; k < grants.size(); k++) begin
`ifdef AVR_IO_ARB_RR_EN
         chk("grant_order", grants[k], k % 2);
`else
         chk("grant_order", grants[k], (k % (LIM + 1)) == LIM ? 1 : 0);
`endif
      end
      tick();
      note_write(6'h20, 8'h11);
      note_write(6'h21, 8'h22);

      // reset while in RD_ADDR aborts the read, which then restarts after release
      do_reset();
      set_req(1, 1'b0, 6'h18, 8'h00);
      tick();
      chk("pre_abort_read", io_read, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_read", {io_read, m0.ack, m1.ack}, 0);
      chk("abort_rdata", m1.rdata, 0);
      tick();
      rst_n = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!m1.ack && n < 10);
      chk("restart_latency", n, 2);
      chk("restart_rdata", m1.rdata, ref_mem[6'h18]);
      drop(1);
      tick();

      // m0 drops its request mid-read; its ack still arrives, then m1 is served
      do_reset();
      set_req(0, 1'b0, 6'h17, 8'h00);
      set_req(1, 1'b1, 6'h30, 8'h5A);
      tick();
      chk("m0_first", {io_read, io_addr}, {1'b1, 6'h17});
      drop(0);
      tick();
      chk("dropped_ack", {m0.ack, m1.ack}, 2'b10);
      chk("dropped_rdata", m0.rdata, ref_mem[6'h17]);
      tick();
      chk("gap_idle", {io_write, io_read, io_oe, m0.ack, m1.ack}, 0);
      tick();
      chk("m1_after", {m1.ack, m0.ack, io_write, io_addr, io_wdata}, {1'b1, 1'b0, 1'b1, 6'h30, 8'h5A});
      note_write(6'h30, 8'h5A);
      drop(1);
      tick();

      // random isolated transactions against the reference memory
      for (int i = 0; i < 40; i++) begin
         p = $urandom_range(0, 1);
         we = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         a = we ? 6'($urandom) : written[$urandom_range(0, written.size() - 1)];
         txn(p, we, a, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
